// File: rtl/mult_job_issuer_if.sv
// Bundle of operand, multiplier and result signals for mult_job_issuer.
// Handshakes: a transfer on in_* or out_* happens on a rising clk edge where
// valid and ready are both high; a valid source holds its payload stable
// until that edge, and ready never depends combinationally on valid.
// dbg_state / dbg_count expose the FSM state and FIFO occupancy for checkers.
interface mult_job_issuer_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   logic [WIDTH-1:0]         mul_a;
   logic [WIDTH-1:0]         mul_b;
   logic                     mul_start;
   logic                     mul_done;
   logic [2*WIDTH-1:0]       mul_z;
   logic                     out_valid;
   logic                     out_ready;
   logic [2*WIDTH-1:0]       out_z;
   logic                     busy;
   logic                     err;
   logic [1:0]               dbg_state;
   logic [$clog2(DEPTH):0]   dbg_count;

   // Environment side: operand source, multiplier datapath, result consumer
   modport master (
      output in_valid, in_a, in_b, mul_done, mul_z, out_ready,
      input  in_ready, mul_a, mul_b, mul_start, out_valid, out_z, busy, err,
             dbg_state, dbg_count
   );

   // Issuer side
   modport slave (
      input  in_valid, in_a, in_b, mul_done, mul_z, out_ready,
      output in_ready, mul_a, mul_b, mul_start, out_valid, out_z, busy, err,
             dbg_state, dbg_count
   );
endinterface

// File: rtl/mult_job_issuer.sv
// mult_job_issuer: queues operand pairs in a small FIFO and feeds them one at a
// time to a sequential multiplier, holding each product on a valid/ready port.
// Optional watchdog on the WAIT state is enabled by defining MUL_TIMEOUT_EN.
module mult_job_issuer #(
   parameter int WIDTH          = 4,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   mult_job_issuer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   // Reject parameter sets the pointer arithmetic or watchdog cannot support
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mult_job_issuer: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mem_a_q [DEPTH];
   logic [WIDTH-1:0]     mem_b_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW:0]          count_q, count_d;
   logic                 full, empty, push, pop;
   logic [WIDTH-1:0]     mul_a_q, mul_b_q;
   logic                 mul_start_q;
   logic                 out_valid_q;
   logic [2*WIDTH-1:0]   out_z_q;

`ifdef MUL_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   logic [WDW-1:0]       wd_q;
   logic                 err_q;
`endif

   // Ready comes only from registered occupancy, so a same-cycle pop never opens it
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = bus.in_valid && !full;
   assign pop   = (state_q == IDLE) && !empty;

   // Next-state pointer and occupancy arithmetic; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   // FIFO storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q] <= bus.in_a;
         mem_b_q[wr_ptr_q] <= bus.in_b;
      end
   end

   // FIFO pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Job sequencer: load head, pulse start, wait for done, hold result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
`ifdef MUL_TIMEOUT_EN
         wd_q        <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  mul_a_q     <= mem_a_q[rd_ptr_q];
                  mul_b_q     <= mem_b_q[rd_ptr_q];
                  mul_start_q <= 1'b1;
                  state_q     <= START;
               end
            end
            START: begin
               mul_start_q <= 1'b0;
               state_q     <= WAIT;
`ifdef MUL_TIMEOUT_EN
               wd_q        <= '0;
`endif
            end
            WAIT: begin
               if (bus.mul_done) begin
                  out_z_q     <= bus.mul_z;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
`ifdef MUL_TIMEOUT_EN
               else if (wd_q == WD_LAST) begin
                  // Abandon the job; the result port stays idle
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = !full;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_start = mul_start_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_z     = out_z_q;
   assign bus.busy      = (state_q != IDLE) || !empty;
   assign bus.dbg_state = state_q;
   assign bus.dbg_count = count_q;
`ifdef MUL_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_job_issuer.sv
// Bench for mult_job_issuer: directed jobs, a multiplier responder, a
// queue-based reference model compared every cycle, and literal spot checks.
module tb_mult_job_issuer;
   localparam int W  = 4;
   localparam int D  = 4;
   localparam int TO = 16;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_job_issuer_if #(.WIDTH(W), .DEPTH(D)) bus ();

   mult_job_issuer #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      total++;
      bad++;
      $display("FAIL %s wait bound expired t=%0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   pair_t          m_fifo[$];
   logic [2*W-1:0] exp_q[$];
   pair_t          m_cur;
   logic [2*W-1:0] m_res;
   bit             m_start, m_wait, m_hold, m_err;
   int             m_wd;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_cur = '0; m_res = '0;
            m_start = 0; m_wait = 0; m_hold = 0; m_err = 0; m_wd = 0;
         end else begin
            int    sz;
            bit    take;
            pair_t np;
            sz   = m_fifo.size();
            take = bus.in_valid && (sz < D);
            np   = '{a: bus.in_a, b: bus.in_b};
            if (m_hold) begin
               if (bus.out_ready) m_hold = 0;
            end else if (m_wait) begin
               if (bus.mul_done) begin
                  m_res  = 8'(int'(m_cur.a) * int'(m_cur.b));
                  exp_q.push_back(m_res);
                  m_hold = 1;
                  m_wait = 0;
               end
`ifdef MUL_TIMEOUT_EN
               else begin
                  m_wd++;
                  if (m_wd == TO) begin
                     m_err  = 1;
                     m_wait = 0;
                  end
               end
`endif
            end else if (m_start) begin
               m_start = 0;
               m_wait  = 1;
               m_wd    = 0;
            end else if (sz > 0) begin
               m_cur   = m_fifo.pop_front();
               m_start = 1;
            end
            if (take) m_fifo.push_back(np);
         end
      end
   end

   // ---------------- per-cycle compare + scoreboard ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_fifo.size() < D));
            chk("mul_start", 32'(bus.mul_start), 32'(m_start));
            chk("mul_a",     32'(bus.mul_a),     32'(m_cur.a));
            chk("mul_b",     32'(bus.mul_b),     32'(m_cur.b));
            chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
            chk("out_z",     32'(bus.out_z),     32'(m_res));
            chk("busy",      32'(bus.busy),      32'(m_start || m_wait || m_hold || m_fifo.size() > 0));
            chk("err",       32'(bus.err),       32'(m_err));
            chk("count",     32'(bus.dbg_count), 32'(m_fifo.size()));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) fail_bound("scoreboard_empty");
               else chk("scoreboard", 32'(bus.out_z), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- multiplier responder ----------------
   bit           mul_en   = 1'b1;
   bit           spur_req = 1'b0;
   int           lat      = 6;
   int           mcnt     = 0;
   int           starts   = 0;
   logic [W-1:0] pa, pb;

   initial begin
      bus.mul_done = 1'b0;
      bus.mul_z    = 8'h5A;
      forever begin
         @(posedge clk); #1;
         bus.mul_done = 1'b0;
         bus.mul_z    = 8'h5A;
         if (bus.dbg_state != S_START && bus.dbg_state != S_WAIT) mcnt = 0;
         if (spur_req) begin
            bus.mul_done = 1'b1;
            spur_req     = 1'b0;
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               bus.mul_done = 1'b1;
               bus.mul_z    = {4'b0, pa} * {4'b0, pb};
            end
         end
         if (bus.mul_start) begin
            starts++;
            if (mul_en) begin
               mcnt = lat;
               pa   = bus.mul_a;
               pb   = bus.mul_b;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      logic acc;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
      fail_bound("push");
   endtask

   task automatic wait_out(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) return;
      end
      fail_bound(name);
   endtask

   logic [2*W-1:0] got[8];
   int             ngot;

   task automatic collect(input int n);
      ngot = 0;
      for (int i = 0; i < 400 && ngot < n; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            got[ngot] = bus.out_z;
            ngot++;
         end
      end
      chk("collect_n", 32'(ngot), 32'(n));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int  s0;
      bit  found;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // reset
      step(1);
      cmp_en = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_z",     32'(bus.out_z),     32'd0);
      chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_err",       32'(bus.err),       32'd0);
      step(1);

      // single job 3*5
      push(4'd3, 4'd5);
      wait_out("single_wait");
      chk("single_z",      32'(bus.out_z), 32'd15);
      chk("single_a",      32'(bus.mul_a), 32'd3);
      chk("single_b",      32'(bus.mul_b), 32'd5);
      chk("single_starts", 32'(starts),    32'd1);
      step(1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("single_hold", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      chk("single_clear", 32'(bus.out_valid), 32'd0);
      step(1);
      bus.out_ready = 1'b0;
      step(2);

      // fill and back-pressure
      push(4'd1, 4'd2);
      push(4'd15, 4'd15);
      push(4'd7, 4'd9);
      push(4'd4, 4'd11);
      push(4'd13, 4'd6);
      @(negedge clk);
      chk("fill_in_ready", 32'(bus.in_ready),  32'd0);
      chk("fill_count",    32'(bus.dbg_count), 32'd4);
      step(1);
      bus.out_ready = 1'b1;
      collect(5);
      chk("order_0", 32'(got[0]), 32'd2);
      chk("order_1", 32'(got[1]), 32'd225);
      chk("order_2", 32'(got[2]), 32'd63);
      chk("order_3", 32'(got[3]), 32'd44);
      chk("order_4", 32'(got[4]), 32'd78);
      step(3);
      chk("drain_busy", 32'(bus.busy), 32'd0);
      bus.out_ready = 1'b0;

      // simultaneous push and pop with two queued
      push(4'd2, 4'd3);
      push(4'd5, 4'd5);
      push(4'd6, 4'd7);
      wait_out("sim_wait");
      step(1);
      bus.out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.dbg_state == S_IDLE && bus.dbg_count == 3'd2) found = 1'b1;
      end
      if (!found) fail_bound("sim_idle");
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd9;
      bus.in_b     = 4'd9;
      step(1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("sim_count",    32'(bus.dbg_count), 32'd2);
      chk("sim_in_ready", 32'(bus.in_ready),  32'd1);
      chk("sim_mul_a",    32'(bus.mul_a),     32'd5);
      step(1);
      bus.out_ready = 1'b1;
      collect(3);
      chk("sim_order_0", 32'(got[0]), 32'd25);
      chk("sim_order_1", 32'(got[1]), 32'd42);
      chk("sim_order_2", 32'(got[2]), 32'd81);
      step(4);
      bus.out_ready = 1'b0;

      // spurious done in IDLE and in HOLD
      s0 = starts;
      spur_req = 1'b1;
      step(3);
      @(negedge clk);
      chk("spur_idle_z",      32'(bus.out_z), 32'd81);
      chk("spur_idle_busy",   32'(bus.busy),  32'd0);
      chk("spur_idle_starts", 32'(starts),    32'(s0));
      step(1);
      push(4'd4, 4'd4);
      wait_out("spur_hold_wait");
      chk("spur_hold_z0", 32'(bus.out_z), 32'd16);
      step(1);
      spur_req = 1'b1;
      step(3);
      @(negedge clk);
      chk("spur_hold_z",     32'(bus.out_z),     32'd16);
      chk("spur_hold_valid", 32'(bus.out_valid), 32'd1);
      step(1);
      bus.out_ready = 1'b1;
      step(3);
      bus.out_ready = 1'b0;

      // reset while in WAIT with two queued
      lat = 20;
      push(4'd1, 4'd1);
      push(4'd2, 4'd2);
      push(4'd3, 4'd3);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.dbg_state == S_WAIT && bus.dbg_count == 3'd2) found = 1'b1;
      end
      if (!found) fail_bound("rst_wait_reach");
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy",  32'(bus.busy),      32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_count", 32'(bus.dbg_count), 32'd0);
      chk("mid_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
      s0 = starts;
      step(30);
      chk("mid_rst_starts", 32'(starts), 32'(s0));
      lat = 6;

`ifdef MUL_TIMEOUT_EN
      // watchdog: multiplier never answers
      mul_en        = 1'b0;
      bus.out_ready = 1'b1;
      push(4'd2, 4'd2);
      push(4'd3, 4'd3);
      s0 = starts;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (bus.err) found = 1'b1;
      end
      if (!found) fail_bound("timeout_err");
      chk("timeout_err",   32'(bus.err),       32'd1);
      chk("timeout_valid", 32'(bus.out_valid), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (bus.mul_start) found = 1'b1;
      end
      if (!found) fail_bound("timeout_next_start");
      chk("timeout_next_a", 32'(bus.mul_a), 32'd3);
      step(40);
      chk("timeout_idle_busy", 32'(bus.busy), 32'd0);
      mul_en        = 1'b1;
      bus.out_ready = 1'b0;
`endif

      step(2);
      chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #400000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "stalled");
   end

endmodule
